// File: rtl/wb_hb_mailbox_pkg.sv
// Shared constants for the Wishbone host-bus mailbox: register offsets,
// STATUS bit positions and the bus-handshake state encoding.
package wb_hb_mailbox_pkg;

    // Register offsets within the 8-word window
    localparam logic [2:0] REG_SCRATCH   = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_H2F_DATA  = 3'd2;
    localparam logic [2:0] REG_F2H_DATA  = 3'd3;
    localparam logic [2:0] REG_H2F_COUNT = 3'd4;
    localparam logic [2:0] REG_F2H_COUNT = 3'd5;

    // STATUS bit positions
    localparam int STAT_H2F_FULL  = 0;
    localparam int STAT_H2F_EMPTY = 1;
    localparam int STAT_F2H_FULL  = 2;
    localparam int STAT_F2H_EMPTY = 3;
    localparam int STAT_H2F_OVF   = 4;
    localparam int STAT_F2H_UNF   = 5;

    // Bus handshake state
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/wb_hb_mailbox_if.sv
// Wishbone classic bus bundle between the host-bus wrapper (master) and the
// mailbox (slave).
interface wb_hb_mailbox_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  wb_cycle;
    logic                  wb_strobe;
    logic                  wb_write;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_wrData;
    logic [DATA_WIDTH-1:0] wb_rdData;
    logic                  wb_ack;

    modport master (
        output wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData,
        input  wb_rdData, wb_ack
    );

    modport slave (
        input  wb_cycle, wb_strobe, wb_write, wb_addr, wb_wrData,
        output wb_rdData, wb_ack
    );
endinterface

// File: rtl/wb_hb_mailbox_fifo.sv
// Single-clock FIFO with show-ahead head word and saturating occupancy count.
// A pop on a full FIFO frees the slot the same edge, so a simultaneous push
// is accepted; a pop on an empty FIFO is ignored.
module hb_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  push_eff;
    logic                  pop_eff;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);
    assign dout     = mem[rd_ptr_reg];
    assign count    = count_reg;

    // Storage array; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks net push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/wb_hb_mailbox.sv
// Wishbone classic slave exposing a scratch register, status and two
// mailbox FIFOs (host-to-fabric and fabric-to-host). Each strobe assertion
// commits exactly one side effect on the edge it is first sampled.
module wb_hb_mailbox
    import wb_hb_mailbox_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_hb_mailbox_if.slave        bus,
    output logic [DATA_WIDTH-1:0] h2f_data,
    output logic                  h2f_valid,
    input  logic                  h2f_pop,
    input  logic [DATA_WIDTH-1:0] f2h_data,
    input  logic                  f2h_push,
    output logic                  f2h_full,
    output logic                  irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_t            state_reg;
    bus_state_t            state_next;
    logic                  hit;
    logic                  commit;
    logic [2:0]            reg_offset;

    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [DATA_WIDTH-1:0] rd_data_next;
    logic [DATA_WIDTH-1:0] scratch_reg;
    logic                  ovf_reg;
    logic                  unf_reg;
    logic [DATA_WIDTH-1:0] status_word;

    logic                  scratch_we;
    logic                  status_we;
    logic                  host_h2f_push;
    logic                  host_f2h_pop;
    logic                  ovf_set;
    logic                  unf_set;

    logic [CW-1:0]         h2f_count;
    logic                  h2f_full;
    logic                  h2f_empty;
    logic [DATA_WIDTH-1:0] f2h_dout;
    logic [CW-1:0]         f2h_count;
    logic                  f2h_empty;

    assign reg_offset = bus.wb_addr[2:0];
    assign hit = bus.wb_cycle & bus.wb_strobe &
                 (bus.wb_addr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);

    // Handshake state register; async reset drops ack immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // Next state: accept a hit in IDLE, hold ACK until strobe/cycle drop
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (hit) state_next = S_ACK;
            S_ACK:   if (!bus.wb_cycle || !bus.wb_strobe) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: ack follows state; commit strobes only on the accepting edge
    always_comb begin
        bus.wb_ack    = (state_reg == S_ACK);
        commit        = (state_reg == S_IDLE) & hit;
        scratch_we    = commit &  bus.wb_write & (reg_offset == REG_SCRATCH);
        status_we     = commit &  bus.wb_write & (reg_offset == REG_STATUS);
        host_h2f_push = commit &  bus.wb_write & (reg_offset == REG_H2F_DATA);
        host_f2h_pop  = commit & ~bus.wb_write & (reg_offset == REG_F2H_DATA);
    end

    // Overflow only when the push really is dropped (a same-edge user pop
    // makes room); underflow whenever the host pops an empty F2H
    assign ovf_set = host_h2f_push & h2f_full & ~h2f_pop;
    assign unf_set = host_f2h_pop & f2h_empty;

    // STATUS word assembly
    always_comb begin
        status_word                 = '0;
        status_word[STAT_H2F_FULL]  = h2f_full;
        status_word[STAT_H2F_EMPTY] = h2f_empty;
        status_word[STAT_F2H_FULL]  = f2h_full;
        status_word[STAT_F2H_EMPTY] = f2h_empty;
        status_word[STAT_H2F_OVF]   = ovf_reg;
        status_word[STAT_F2H_UNF]   = unf_reg;
    end

    // Read mux on pre-commit state; writes return zero
    always_comb begin
        rd_data_next = '0;
        if (!bus.wb_write) begin
            case (reg_offset)
                REG_SCRATCH:   rd_data_next = scratch_reg;
                REG_STATUS:    rd_data_next = status_word;
                REG_F2H_DATA:  rd_data_next = f2h_empty ? '0 : f2h_dout;
                REG_H2F_COUNT: rd_data_next = DATA_WIDTH'(h2f_count);
                REG_F2H_COUNT: rd_data_next = DATA_WIDTH'(f2h_count);
                default:       rd_data_next = '0;
            endcase
        end
    end

    // Registered read data and host-visible registers; sticky set beats W1C
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_reg <= '0;
            scratch_reg <= '0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
        end else begin
            if (commit)     rd_data_reg <= rd_data_next;
            if (scratch_we) scratch_reg <= bus.wb_wrData;
            ovf_reg <= ovf_set | (ovf_reg & ~(status_we & bus.wb_wrData[STAT_H2F_OVF]));
            unf_reg <= unf_set | (unf_reg & ~(status_we & bus.wb_wrData[STAT_F2H_UNF]));
        end
    end

    assign bus.wb_rdData = rd_data_reg;

    hb_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_h2f (
        .clk   (clk),
        .rst   (rst),
        .push  (host_h2f_push),
        .din   (bus.wb_wrData),
        .pop   (h2f_pop),
        .dout  (h2f_data),
        .count (h2f_count),
        .full  (h2f_full),
        .empty (h2f_empty)
    );

    hb_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_f2h (
        .clk   (clk),
        .rst   (rst),
        .push  (f2h_push),
        .din   (f2h_data),
        .pop   (host_f2h_pop),
        .dout  (f2h_dout),
        .count (f2h_count),
        .full  (f2h_full),
        .empty (f2h_empty)
    );

    assign h2f_valid = ~h2f_empty;
    assign irq       = ~h2f_empty | ovf_reg | unf_reg;

endmodule

// File: tb/tb_wb_hb_mailbox.sv
// Self-checking bench for wb_hb_mailbox: a register-access table, hand-written
// FIFO/reset sequences and a randomized phase against a queue-based model.
module tb_wb_hb_mailbox;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_hb_mailbox_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [DW-1:0] h2f_data;
    logic          h2f_valid;
    logic          h2f_pop;
    logic [DW-1:0] f2h_data;
    logic          f2h_push;
    logic          f2h_full;
    logic          irq;

    wb_hb_mailbox #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (16'h0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .h2f_data  (h2f_data),
        .h2f_valid (h2f_valid),
        .h2f_pop   (h2f_pop),
        .f2h_data  (f2h_data),
        .f2h_push  (f2h_push),
        .f2h_full  (f2h_full),
        .irq       (irq)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: mailbox contents as plain queues and flags
    logic [15:0] m_scratch;
    logic [15:0] m_h2f[$];
    logic [15:0] m_f2h[$];
    bit          m_ovf;
    bit          m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_scratch = '0;
        m_h2f.delete();
        m_f2h.delete();
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s = '0;
        s[0] = (m_h2f.size() == DEPTH);
        s[1] = (m_h2f.size() == 0);
        s[2] = (m_f2h.size() == DEPTH);
        s[3] = (m_f2h.size() == 0);
        s[4] = m_ovf;
        s[5] = m_unf;
        return s;
    endfunction

    // One committed bus access plus optional user pop/push on the same edge.
    // Register reads see the state before that edge.
    function automatic logic [15:0] model_access(input bit we, input logic [15:0] addr,
                                                 input logic [15:0] wd, input bit spop,
                                                 input bit spush, input logic [15:0] sdata);
        logic [15:0] rd;
        bit hit;
        int off;
        rd  = '0;
        hit = (addr[15:3] == 13'd0);
        off = int'(addr[2:0]);
        if (hit && !we) begin
            if (off == 0) rd = m_scratch;
            if (off == 1) rd = model_status();
            if (off == 4) rd = 16'(m_h2f.size());
            if (off == 5) rd = 16'(m_f2h.size());
        end
        if (spop && m_h2f.size() > 0) void'(m_h2f.pop_front());
        if (hit && we && off == 2) begin
            if (m_h2f.size() < DEPTH) m_h2f.push_back(wd);
            else m_ovf = 1;
        end
        if (hit && we && off == 0) m_scratch = wd;
        if (hit && we && off == 1) begin
            if (wd[4]) m_ovf = 0;
            if (wd[5]) m_unf = 0;
        end
        if (hit && !we && off == 3) begin
            if (m_f2h.size() > 0) rd = m_f2h.pop_front();
            else m_unf = 1;
        end
        if (spush && m_f2h.size() < DEPTH) m_f2h.push_back(sdata);
        return rd;
    endfunction

    // Host access holding strobe for 1+hold ack cycles; checks ack timing,
    // read-data stability and (for reads) the model's data.
    task automatic host(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                        input int hold, input bit spop, input bit spush,
                        input logic [15:0] sdata, input string name,
                        output logic [15:0] rd);
        bit hit;
        bit ok;
        logic [15:0] exp;
        hit = (addr[15:3] == 13'd0);
        ok  = 1;
        exp = model_access(we, addr, wd, spop, spush, sdata);
        @(negedge clk);
        bus.wb_cycle  = 1;
        bus.wb_strobe = 1;
        bus.wb_write  = we;
        bus.wb_addr   = addr;
        bus.wb_wrData = wd;
        h2f_pop  = spop;
        f2h_push = spush;
        f2h_data = sdata;
        @(negedge clk);
        h2f_pop  = 0;
        f2h_push = 0;
        // Scramble the request while ack is held; it must be ignored
        bus.wb_addr   = addr ^ 16'h0005;
        bus.wb_wrData = ~wd;
        bus.wb_write  = ~we;
        if (bus.wb_ack !== hit) ok = 0;
        rd = bus.wb_rdData;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.wb_ack !== hit || (hit && bus.wb_rdData !== rd)) ok = 0;
        end
        bus.wb_strobe = 0;
        bus.wb_cycle  = 0;
        @(negedge clk);
        if (bus.wb_ack !== 1'b0) ok = 0;
        check({name, " ack"}, 32'(ok), 32'd1);
        if (hit && !we) check({name, " rd"}, 32'(rd), 32'(exp));
    endtask

    task automatic user_push(input logic [15:0] d);
        @(negedge clk);
        f2h_push = 1;
        f2h_data = d;
        if (m_f2h.size() < DEPTH) m_f2h.push_back(d);
        @(negedge clk);
        f2h_push = 0;
    endtask

    task automatic user_pop(input string name);
        @(negedge clk);
        check({name, " h2f_valid"}, 32'(h2f_valid), 32'(m_h2f.size() > 0));
        if (m_h2f.size() > 0) begin
            check({name, " h2f_data"}, 32'(h2f_data), 32'(m_h2f[0]));
            void'(m_h2f.pop_front());
        end
        h2f_pop = 1;
        @(negedge clk);
        h2f_pop = 0;
    endtask

    task automatic check_flags(input string name);
        check({name, " irq"}, 32'(irq), 32'(m_h2f.size() > 0 || m_ovf || m_unf));
        check({name, " h2f_valid"}, 32'(h2f_valid), 32'(m_h2f.size() > 0));
        check({name, " f2h_full"}, 32'(f2h_full), 32'(m_f2h.size() == DEPTH));
    endtask

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wd;
        int          hold;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;

        tbl[0]  = '{1'b1, 16'h0000, 16'hA5A5, 10, 16'h0000};
        tbl[1]  = '{1'b0, 16'h0000, 16'h0000,  0, 16'hA5A5};
        tbl[2]  = '{1'b0, 16'h0001, 16'h0000,  2, 16'h000A};
        tbl[3]  = '{1'b0, 16'h0002, 16'h0000,  0, 16'h0000};
        tbl[4]  = '{1'b1, 16'h0006, 16'hDEAD,  1, 16'h0000};
        tbl[5]  = '{1'b0, 16'h0006, 16'h0000,  0, 16'h0000};
        tbl[6]  = '{1'b0, 16'h0007, 16'h0000,  0, 16'h0000};
        tbl[7]  = '{1'b0, 16'h0003, 16'h0000,  0, 16'h0000};
        tbl[8]  = '{1'b0, 16'h0001, 16'h0000,  0, 16'h002A};
        tbl[9]  = '{1'b1, 16'h0001, 16'h0020,  0, 16'h0000};
        tbl[10] = '{1'b0, 16'h0001, 16'h0000,  0, 16'h000A};
        tbl[11] = '{1'b0, 16'h0004, 16'h0000,  0, 16'h0000};
        tbl[12] = '{1'b1, 16'h0003, 16'h1234,  0, 16'h0000};
        tbl[13] = '{1'b0, 16'h0005, 16'h0000,  3, 16'h0000};

        rst = 0;
        bus.wb_cycle = 0; bus.wb_strobe = 0; bus.wb_write = 0;
        bus.wb_addr = '0; bus.wb_wrData = '0;
        h2f_pop = 0; f2h_push = 0; f2h_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset ack", 32'(bus.wb_ack), 32'd0);
        check("reset rdData", 32'(bus.wb_rdData), 32'd0);
        check("reset h2f_valid", 32'(h2f_valid), 32'd0);
        check("reset irq", 32'(irq), 32'd0);
        rst = 1;
        @(negedge clk);

        // Register-access table
        for (int i = 0; i < 14; i++) begin
            host(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].hold, 0, 0, '0,
                 $sformatf("tbl%0d", i), rd);
            if (!tbl[i].we) check($sformatf("tbl%0d expected", i), 32'(rd), 32'(tbl[i].exp));
        end
        check_flags("after table");

        // H2F fill to full, then one overflowing write
        for (int v = 1; v <= 16; v++) host(1, 16'h0002, 16'(v), 0, 0, 0, '0, "h2f fill", rd);
        host(1, 16'h0002, 16'd99, 2, 0, 0, '0, "h2f overflow", rd);
        host(0, 16'h0004, '0, 0, 0, 0, '0, "h2f count full", rd);
        check("h2f count is 16", 32'(rd), 32'd16);
        host(0, 16'h0001, '0, 0, 0, 0, '0, "status full", rd);
        check("status h2f_full", 32'(rd[0]), 32'd1);
        check("status h2f_ovf", 32'(rd[4]), 32'd1);
        check_flags("h2f full");
        for (int v = 1; v <= 16; v++) begin
            @(negedge clk);
            check($sformatf("h2f pop order %0d", v), 32'(h2f_data), 32'(v));
            user_pop("h2f drain");
        end
        @(negedge clk);
        check("h2f_valid after drain", 32'(h2f_valid), 32'd0);
        host(1, 16'h0001, 16'h0010, 0, 0, 0, '0, "clear ovf", rd);
        host(0, 16'h0001, '0, 0, 0, 0, '0, "status cleared", rd);
        check("status after ovf clear", 32'(rd), 32'h000A);

        // Full H2F: host push with user pop on the same edge is accepted
        for (int v = 0; v < 16; v++) host(1, 16'h0002, 16'(200 + v), 0, 0, 0, '0, "h2f refill", rd);
        host(1, 16'h0002, 16'd300, 0, 1, 0, '0, "h2f full push+pop", rd);
        host(0, 16'h0004, '0, 0, 0, 0, '0, "h2f count push+pop", rd);
        check("h2f count unchanged", 32'(rd), 32'd16);
        host(0, 16'h0001, '0, 0, 0, 0, '0, "status no ovf", rd);
        check("no ovf on push+pop", 32'(rd[4]), 32'd0);
        for (int v = 0; v < 16; v++) user_pop("h2f drain2");
        // Empty H2F: host push with user pop -> push only
        host(1, 16'h0002, 16'h0077, 0, 1, 0, '0, "h2f empty push+pop", rd);
        host(0, 16'h0004, '0, 0, 0, 0, '0, "h2f count empty push+pop", rd);
        check("h2f count after empty push+pop", 32'(rd), 32'd1);
        user_pop("h2f single");

        // F2H pops including underflow, then W1C clear
        user_push(16'h0010);
        user_push(16'h0020);
        host(0, 16'h0003, '0, 0, 0, 0, '0, "f2h read1", rd);
        check("f2h first word", 32'(rd), 32'h0010);
        host(0, 16'h0003, '0, 0, 0, 0, '0, "f2h read2", rd);
        check("f2h second word", 32'(rd), 32'h0020);
        host(0, 16'h0003, '0, 0, 0, 0, '0, "f2h read3", rd);
        check("f2h empty read", 32'(rd), 32'h0000);
        host(0, 16'h0001, '0, 0, 0, 0, '0, "status unf", rd);
        check("status f2h_unf set", 32'(rd[5]), 32'd1);
        check_flags("unf irq");
        host(1, 16'h0001, 16'h0020, 0, 0, 0, '0, "clear unf", rd);
        host(0, 16'h0001, '0, 0, 0, 0, '0, "status unf cleared", rd);
        check("status f2h_unf clear", 32'(rd[5]), 32'd0);

        // Host pop and user push on the same edge of a non-empty F2H
        user_push(16'd1);
        user_push(16'd2);
        user_push(16'd3);
        host(0, 16'h0003, '0, 1, 0, 1, 16'd4, "f2h pop+push", rd);
        check("f2h pop+push data", 32'(rd), 32'd1);
        host(0, 16'h0005, '0, 0, 0, 0, '0, "f2h count pop+push", rd);
        check("f2h count unchanged", 32'(rd), 32'd3);
        for (int v = 2; v <= 4; v++) begin
            host(0, 16'h0003, '0, 0, 0, 0, '0, "f2h order", rd);
            check($sformatf("f2h order %0d", v), 32'(rd), 32'(v));
        end

        // Outside the window: no ack, no side effect
        host(1, 16'h0008, 16'h5555, 3, 0, 0, '0, "miss write", rd);
        host(0, 16'hFFF8, '0, 2, 0, 0, '0, "miss read", rd);
        host(0, 16'h0000, '0, 0, 0, 0, '0, "scratch after miss", rd);
        check("scratch kept", 32'(rd), 32'hA5A5);

        // Reset in the middle of an acknowledged access
        for (int v = 0; v < 3; v++) host(1, 16'h0002, 16'(v + 40), 0, 0, 0, '0, "pre-reset h2f", rd);
        for (int v = 0; v < 3; v++) user_push(16'(v + 50));
        @(negedge clk);
        bus.wb_cycle = 1; bus.wb_strobe = 1; bus.wb_write = 0; bus.wb_addr = 16'h0000;
        @(negedge clk);
        check("ack before reset", 32'(bus.wb_ack), 32'd1);
        #2 rst = 0;
        #1;
        check("ack dropped by reset", 32'(bus.wb_ack), 32'd0);
        check("h2f_valid after reset", 32'(h2f_valid), 32'd0);
        check("irq after reset", 32'(irq), 32'd0);
        @(negedge clk);
        bus.wb_cycle = 0; bus.wb_strobe = 0;
        rst = 1;
        model_reset();
        host(0, 16'h0004, '0, 0, 0, 0, '0, "h2f count after reset", rd);
        host(0, 16'h0005, '0, 0, 0, 0, '0, "f2h count after reset", rd);
        host(0, 16'h0000, '0, 0, 0, 0, '0, "scratch after reset", rd);

        // Randomized mix against the model
        for (int n = 0; n < 250; n++) begin
            int op;
            op = int'($urandom_range(0, 6));
            if (op <= 3) begin
                logic [15:0] a;
                bit we;
                a  = (op == 3) ? 16'h0002 : 16'($urandom_range(0, 8));
                we = (op == 3) ? 1'b1 : 1'($urandom_range(0, 1));
                host(we, a, 16'($urandom), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     16'($urandom), $sformatf("rand%0d a%0d w%0d", n, a, we), rd);
            end else if (op == 4 || op == 5) begin
                user_push(16'($urandom));
            end else begin
                user_pop($sformatf("rand%0d pop", n));
            end
            @(negedge clk);
            check_flags($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_hb_mailbox.md
Name: wb_hb_mailbox

Overview:
- Wishbone classic slave directly downstream of the host-bus-to-Wishbone wrapper. It consumes wb_cycle/wb_strobe/wb_write/wb_addr/wb_wrData and returns wb_rdData/wb_ack.
- Provides a small register window with two FIFOs:
  - H2F: host to fabric.
  - F2H: fabric to host.
- Gives host software a buffered mailbox to user logic on the Spartan-6 side.
- Each host access may hold strobe for many clocks. The block commits exactly one side effect per strobe assertion.

Parameters:
DATA_WIDTH, 16, Wishbone data width and FIFO word width
ADDR_WIDTH, 16, Wishbone address width (word addresses)
BASE_ADDR, 16'h0000, window base; low 3 bits must be 0
FIFO_DEPTH, 16, entries per FIFO; power of 2, at least 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
wb_cycle  in  1  bus cycle
wb_strobe  in  1  strobe
wb_write  in  1  1 = write, 0 = read
wb_addr  in  ADDR_WIDTH  word address
wb_wrData  in  DATA_WIDTH  write data
wb_rdData  out  DATA_WIDTH  read data, registered
wb_ack  out  1  acknowledge, registered
h2f_data  out  DATA_WIDTH  H2F head word, valid when h2f_valid=1
h2f_valid  out  1  H2F not empty
h2f_pop  in  1  user pop; ignored when empty
f2h_data  in  DATA_WIDTH  user push data
f2h_push  in  1  user push; dropped when full
f2h_full  out  1  F2H full
irq  out  1  level: H2F non-empty OR any sticky bit set

Behaviour:
- Reset (rst=0, async): wb_ack=0, wb_rdData=0, both FIFOs empty, SCRATCH=0, sticky bits=0, FSM=IDLE, irq=0.
- Hit: wb_cycle & wb_strobe & (wb_addr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]). Non-hit: no ack, no side effects.
- Register map (offset = wb_addr[2:0]):
  - 0 SCRATCH: RW.
  - 1 STATUS:
    - RO bits: 0 h2f_full, 1 h2f_empty, 2 f2h_full, 3 f2h_empty.
    - Sticky bits, write-1-to-clear: 4 h2f_ovf, 5 f2h_unf.
    - Other bits read 0.
  - 2 H2F_DATA: WO push; reads 0.
  - 3 F2H_DATA: RO pop; writes ignored.
  - 4 H2F_COUNT: RO.
  - 5 F2H_COUNT: RO.
  - 6-7: read 0, writes ignored, still acked.
- FSM states IDLE, ACK:
  - IDLE: on a hit sampled at edge N, latch write/addr/data and commit the side effect at that edge. Load wb_rdData and set wb_ack=1, both visible in cycle N+1. Go to ACK.
  - ACK: wb_ack stays 1 and wb_rdData stays stable until wb_strobe or wb_cycle is sampled low. Then wb_ack=0 next cycle, state returns to IDLE.
  - Changes to addr/write/data while in ACK are ignored.
  - A new access requires strobe to be deasserted for at least one sampled cycle.
- Latency: 1 clock from strobe sampled to ack.
- H2F push when full: data dropped, h2f_ovf set.
- F2H pop when empty: returns 0, f2h_unf set.
- F2H read returns the head word and pops it in the same commit edge.
- Counts: width $clog2(FIFO_DEPTH)+1, saturating range 0..FIFO_DEPTH; full when count==FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop on one FIFO in the same cycle:
  - Non-empty FIFO: both take effect, count unchanged.
  - Empty FIFO: push only.
  - Full FIFO: pop takes effect and the push is accepted (count unchanged).
- Sticky set and W1C clear in the same cycle: set wins.
- Reset mid-access: ack drops immediately. The host sees no ack and retries.

Decomposition:
- Package wb_hb_mailbox_pkg:
  - Register offset constants: REG_SCRATCH..REG_F2H_COUNT.
  - STATUS bit index constants.
  - FSM state encoding.
- Sub-module hb_sync_fifo: parameterised DATA_WIDTH and DEPTH, single-clock, with push, pop, dout, count, full, empty. Instantiated twice.

Test Plan:
- Write 16'hA5A5 to BASE+0 with strobe held 10 cycles, then read BASE+0 -> exactly one ack window per access; ack at cycle+1; read returns 16'hA5A5.
- 16 writes to BASE+2 (values 1..16), then a 17th write of 99 -> H2F_COUNT=16; STATUS bit0=1, bit4=1. User pops yield 1..16 in order; h2f_valid=0 after the last pop.
- User pushes 0x10, 0x20; host reads BASE+3 three times -> 0x10, 0x20, 0; STATUS bit5=1. Write 16'h0020 to STATUS -> bit5=0.
- Read BASE+3 while f2h_push is asserted with a non-empty F2H FIFO -> F2H_COUNT unchanged; data order preserved.
- Access BASE+8 (outside the window) -> wb_ack never asserts; no state change.
- Drive rst low during the ACK state with the FIFOs holding 3 entries -> wb_ack=0 immediately; both counts 0; irq=0.
